if_id_elastic_reg: RTL and testbench
====================================

// Module: if_id_elastic_reg
// PURPOSE
//   Parametrised IF/ID pipeline register with a valid/ready handshake. It replaces the fixed-width
//   stall-driven flop pair between fetch and decode. Adds per-beat valid tracking, flush with NOP
//   injection, and an optional 1-entry skid buffer so that in_ready is a registered signal.
//   Sits between the IF stage (PC + fetched instruction) and the ID stage.
// PARAMETERS
//   ADDR_WIDTH  32            width of addr_i/addr_o
//   INST_WIDTH  32            width of inst_i/inst_o
//   NOP_INST    32'h0000_0000 instruction driven on inst_o when no valid beat is held
//   RESET_ADDR  32'h0000_0000 addr_o value after reset
//   SKID_EN     1             1: skid buffer, registered in_ready; 0: single register, combinational in_ready
// PORTS
//   clk        in   1           clock, all state updates on rising edge
//   rst        in   1           synchronous reset, active-low
//   flush      in   1           discard all held and incoming beats (branch/exception redirect)
//   in_valid   in   1           IF presents a beat
//   in_ready   out  1           stage can accept a beat this cycle
//   addr_i     in   ADDR_WIDTH  fetch address
//   inst_i     in   INST_WIDTH  fetched instruction
//   out_valid  out  1           ID-facing beat valid
//   out_ready  in   1           ID accepts the beat (low = ID stall)
//   addr_o     out  ADDR_WIDTH  address of held beat
//   inst_o     out  INST_WIDTH  instruction of held beat, NOP_INST when out_valid=0
// BEHAVIOUR
//   - Accept = in_valid & in_ready; drain = out_valid & out_ready. Latency 1 cycle input->output.
//     Throughput 1 beat/cycle. Strict FIFO order; no beat is duplicated or lost except by flush.
//   - Reset (rst=0 at edge): out_valid=0, skid empty, addr_o=RESET_ADDR, inst_o=NOP_INST.
//     in_ready=0 while rst=0. in_ready=1 in the first cycle after release.
//   - State (SKID_EN=1) is one of EMPTY, ONE (output reg full), or TWO (output + skid full).
//       EMPTY: accept -> ONE.
//       ONE:   accept & drain -> ONE (new beat to output); accept & !drain -> TWO (beat to skid);
//              !accept & drain -> EMPTY.
//       TWO:   in_ready=0; drain -> ONE (skid moves to output, skid cleared).
//     in_ready = (state!=TWO), taken from a flop; it has no combinational path from out_ready.
//   - SKID_EN=0: in_ready = !out_valid | out_ready (combinational). Accept loads the output
//     register directly. State TWO is unreachable.
//   - Output regs load only on the transitions above. When ID stalls (out_ready=0) with out_valid=1,
//     addr_o/inst_o are held stable.
//   - While out_valid=0: inst_o=NOP_INST and addr_o holds its last value.
//   - flush=1 at an edge: next state EMPTY (out_valid=0, skid cleared, inst_o=NOP_INST). A beat
//     presented in the flush cycle is discarded even if in_ready=1. flush has priority over accept
//     and drain. rst has priority over flush.
//   - A drain in a flush cycle still counts as consumed by ID. The flush affects only the next state.
//   - Reset asserted mid-transfer drops all held beats; no partial state survives.
// TESTING
//   1 reset: hold rst=0 3 cycles, release -> out_valid=0, inst_o=0, addr_o=RESET_ADDR, in_ready=1
//   2 streaming: out_ready=1, beats A0..A7 (addr 0x100+4n) back-to-back -> each at output 1 cycle
//     later, in order, no gaps
//   3 ID stall, SKID_EN=1: 2 beats accepted while out_ready=0 -> in_ready=0 on next edge, addr_o
//     stable at first beat; out_ready=1 for 2 cycles -> both beats out in order, in_ready=1
//   4 flush in TWO state with in_valid=1 -> next cycle out_valid=0, inst_o=NOP_INST, in_ready=1;
//     none of the 3 beats ever appear
//   5 SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 ->
//     in_ready=1 in the same cycle, and the new beat is loaded on that edge
//   6 random valid/ready 10k cycles vs scoreboard: order kept, no loss or duplication, no stall
//     change of outputs

Source files
------------

// File: rtl/if_id_elastic_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush and optional skid slot.
// With SKID_EN=1, in_ready comes from a flop and has no path from out_ready.
module if_id_elastic_reg #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = '0,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter bit                    SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [INST_WIDTH-1:0] inst_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [INST_WIDTH-1:0] inst;
    } beat_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    beat_t  r_out;
    beat_t  r_skid;
    logic   r_valid;
    logic   r_ready;

    beat_t  w_in;
    logic   w_ready;
    logic   w_acc;
    logic   w_drn;

    assign w_in = {addr_i, inst_i};

    // Held low during reset; otherwise the flop (skid) or the bypass (no skid).
    assign w_ready = SKID_EN ? r_ready : (!r_valid || out_ready);
    assign in_ready = rst && w_ready;

    assign w_acc = in_valid && in_ready;
    assign w_drn = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_out   <= {RESET_ADDR, NOP_INST};
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_skid  <= '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_out   <= w_in;
                        r_valid <= 1'b1;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_drn) begin
                        r_out <= w_in;
                    end else if (w_acc && SKID_EN) begin
                        r_skid  <= w_in;
                        r_ready <= 1'b0;
                        r_state <= S_TWO;
                    end else if (w_drn) begin
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_drn) begin
                        r_out   <= r_skid;
                        r_skid  <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign addr_o    = r_out.addr;
    assign inst_o    = r_valid ? r_out.inst : NOP_INST;

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// Bench for if_id_elastic_reg: vector table, directed corner sequences,
// and a random valid/ready run against a queue model.
module tb_if_id_elastic_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] addr_i;
    logic [31:0] inst_i;
    logic        out_ready;
    logic        out_ready0;

    logic        in_ready, out_valid;
    logic [31:0] addr_o, inst_o;
    logic        in_ready0, out_valid0;
    logic [31:0] addr_o0, inst_o0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_elastic_reg #(
        .SKID_EN (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr_i    (addr_i),
        .inst_i    (inst_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr_o    (addr_o),
        .inst_o    (inst_o)
    );

    if_id_elastic_reg #(
        .NOP_INST   (32'h0000_0013),
        .RESET_ADDR (32'h8000_0000),
        .SKID_EN    (1'b0)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .addr_i    (addr_i),
        .inst_i    (inst_i),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .addr_o    (addr_o0),
        .inst_o    (inst_o0)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] a;
        logic [31:0] i;
        logic        ev;
        logic        er;
        logic [31:0] ea;
        logic [31:0] ei;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] i;
    } beat_t;

    vec_t  vt[$];
    beat_t q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic fl, input logic iv, input logic ordy,
                        input logic [31:0] a, input logic [31:0] i,
                        input logic ev, input logic er,
                        input logic [31:0] ea, input logic [31:0] ei);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.a = a; v.i = i;
        v.ev = ev; v.er = er; v.ea = ea; v.ei = ei;
        vt.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] a, input logic [31:0] i);
        @(negedge clk);
        flush = fl; in_valid = iv; out_ready = ordy;
        addr_i = a; inst_i = i;
    endtask

    initial begin
        // streaming
        for (int n = 0; n < 8; n++)
            addv(0, 1, 1, 32'h100 + 4 * n, 32'hA000_0000 + n,
                 1, 1, 32'h100 + 4 * n, 32'hA000_0000 + n);
        addv(0, 0, 1, 0, 0, 0, 1, 32'h11C, 0);
        // stall into skid, refused beat, drain in order
        addv(0, 1, 0, 32'h200, 32'hB0, 1, 1, 32'h200, 32'hB0);
        addv(0, 1, 0, 32'h204, 32'hB1, 1, 0, 32'h200, 32'hB0);
        addv(0, 1, 0, 32'h208, 32'hB2, 1, 0, 32'h200, 32'hB0);
        addv(0, 0, 1, 0, 0, 1, 1, 32'h204, 32'hB1);
        addv(0, 0, 1, 0, 0, 0, 1, 32'h204, 0);
        // flush in TWO with a beat presented
        addv(0, 1, 0, 32'h300, 32'hC0, 1, 1, 32'h300, 32'hC0);
        addv(0, 1, 0, 32'h304, 32'hC1, 1, 0, 32'h300, 32'hC0);
        addv(1, 1, 0, 32'h308, 32'hC2, 0, 1, 32'h300, 0);
        addv(0, 0, 1, 0, 0, 0, 1, 32'h300, 0);
        addv(0, 1, 1, 32'h400, 32'hD0, 1, 1, 32'h400, 32'hD0);
        // flush coinciding with drain and accept
        addv(0, 1, 1, 32'h404, 32'hE0, 1, 1, 32'h404, 32'hE0);
        addv(1, 1, 1, 32'h408, 32'hE1, 0, 1, 32'h404, 0);
        addv(0, 0, 0, 0, 0, 0, 1, 32'h404, 0);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        addr_i = '0; inst_i = '0; out_ready = 1'b1; out_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.in_ready", in_ready, 1);
        chk("rel.out_valid", out_valid, 0);
        chk("rel.inst", inst_o, 0);
        chk("rel.addr", addr_o, 0);

        foreach (vt[k]) begin
            drive(vt[k].fl, vt[k].iv, vt[k].ordy, vt[k].a, vt[k].i);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", k), out_valid, vt[k].ev);
            chk($sformatf("v%0d.ready", k), in_ready, vt[k].er);
            chk($sformatf("v%0d.addr", k), addr_o, vt[k].ea);
            chk($sformatf("v%0d.inst", k), inst_o, vt[k].ei);
        end

        // reset while two beats are held
        drive(0, 1, 0, 32'h600, 32'hA6);
        drive(0, 1, 0, 32'h604, 32'hA7);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; addr_i = 32'h608;
        @(posedge clk);
        #1;
        chk("mrst.valid", out_valid, 0);
        chk("mrst.addr", addr_o, 0);
        chk("mrst.inst", inst_o, 0);
        chk("mrst.ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("mrst.rel_ready", in_ready, 1);
        chk("s0.rst_valid", out_valid0, 0);
        chk("s0.rst_addr", addr_o0, 32'h8000_0000);
        chk("s0.rst_inst", inst_o0, 32'h13);
        chk("s0.rst_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        chk("mrst.no_ghost", out_valid, 0);

        // no-skid variant: combinational in_ready
        @(negedge clk);
        in_valid = 1'b1; addr_i = 32'h500; inst_i = 32'hF0; out_ready0 = 1'b0;
        @(posedge clk);
        #1;
        chk("s0.valid", out_valid0, 1);
        chk("s0.addr", addr_o0, 32'h500);
        chk("s0.stall_ready", in_ready0, 0);
        @(negedge clk);
        out_ready0 = 1'b1; addr_i = 32'h504; inst_i = 32'hF1;
        #1;
        chk("s0.go_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        chk("s0.load_addr", addr_o0, 32'h504);
        chk("s0.load_inst", inst_o0, 32'hF1);
        @(negedge clk);
        out_ready0 = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s0.hold_addr", addr_o0, 32'h504);
        chk("s0.hold_valid", out_valid0, 1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; addr_i = 32'h508; out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        chk("s0.fl_valid", out_valid0, 0);
        chk("s0.fl_inst", inst_o0, 32'h13);
        chk("s0.fl_addr", addr_o0, 32'h504);

        // random run against queue model (dut empty after flush above)
        begin
            int unsigned seq = 0;
            logic acc, drn;
            for (int c = 0; c < 10000; c++) begin
                @(negedge clk);
                flush     = ($urandom_range(63) == 0);
                in_valid  = ($urandom_range(1) == 1);
                out_ready = ($urandom_range(2) != 0);
                addr_i    = seq * 4;
                inst_i    = $urandom;
                #1;
                chk("rnd.ready", in_ready, (q.size() < 2));
                chk("rnd.valid", out_valid, (q.size() != 0));
                if (q.size() != 0) begin
                    chk("rnd.addr", addr_o, q[0].a);
                    chk("rnd.inst", inst_o, q[0].i);
                end else begin
                    chk("rnd.nop", inst_o, 0);
                end
                acc = in_valid && (q.size() < 2);
                drn = out_ready && (q.size() != 0);
                @(posedge clk);
                if (flush) begin
                    q.delete();
                end else begin
                    if (drn) void'(q.pop_front());
                    if (acc) begin
                        q.push_back({addr_i, inst_i});
                        seq++;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
